// File: rtl/main_control_fsm.sv
// Multicycle main controller for the ARM-subset CPU: sequences fetch/decode/execute/memory/writeback
// and issues raw write requests (later gated by CondEx) plus datapath selects.
module main_control_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic [3:0]         Rd,
    input  logic               MemReady,
    output logic               IRWrite,
    output logic               NextPC,
    output logic               AdrSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUControl,
    output logic [1:0]         ResultSrc,
    output logic               PCS,
    output logic               RegW,
    output logic               MemW,
    output logic [1:0]         FlagW,
    output logic               NoWrite,
    output logic               InstrDone,
    output logic [STATE_W-1:0] State
);

    localparam logic [STATE_W-1:0] FETCH  = STATE_W'(0);
    localparam logic [STATE_W-1:0] DECODE = STATE_W'(1);
    localparam logic [STATE_W-1:0] MEMADR = STATE_W'(2);
    localparam logic [STATE_W-1:0] MEMRD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] MEMWB  = STATE_W'(4);
    localparam logic [STATE_W-1:0] MEMWR  = STATE_W'(5);
    localparam logic [STATE_W-1:0] EXECR  = STATE_W'(6);
    localparam logic [STATE_W-1:0] EXECI  = STATE_W'(7);
    localparam logic [STATE_W-1:0] ALUWB  = STATE_W'(8);
    localparam logic [STATE_W-1:0] BRANCH = STATE_W'(9);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] next_state;
    logic [4:0]         dec;

    // Returns {ALUControl, NoWrite, FlagW} for the data-processing cmd and S bit.
    function automatic logic [4:0] cmd_decode(input logic [5:0] funct);
        logic       s;
        logic [1:0] fw_arith;
        logic [1:0] fw_logic;
        s        = funct[0];
        fw_arith = s ? 2'b11 : 2'b00;
        fw_logic = s ? 2'b10 : 2'b00;
        case (funct[4:1])
            4'b0100: cmd_decode = {2'b00, 1'b0, fw_arith};
            4'b0010: cmd_decode = {2'b01, 1'b0, fw_arith};
            4'b0000: cmd_decode = {2'b10, 1'b0, fw_logic};
            4'b1100: cmd_decode = {2'b11, 1'b0, fw_logic};
            4'b1010: cmd_decode = {2'b01, 1'b1, 2'b11};
            default: cmd_decode = {2'b00, 1'b1, 2'b00};
        endcase
    endfunction

    assign dec = cmd_decode(Funct);

    always_ff @(posedge clk) begin
        if (!reset) state <= FETCH;
        else        state <= next_state;
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:  next_state = MemReady ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    2'b01:   next_state = MEMADR;
                    2'b00:   next_state = Funct[5] ? EXECI : EXECR;
                    2'b10:   next_state = BRANCH;
                    default: next_state = FETCH;
                endcase
            end
            MEMADR: next_state = Funct[0] ? MEMRD : MEMWR;
            MEMRD:  next_state = MemReady ? MEMWB : MEMRD;
            MEMWR:  next_state = MemReady ? FETCH : MEMWR;
            EXECR:  next_state = ALUWB;
            EXECI:  next_state = ALUWB;
            default: next_state = FETCH;
        endcase
    end

    // Outputs are held at zero for the whole reset window, whatever the register holds.
    always_comb begin
        IRWrite    = 1'b0;
        NextPC     = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 2'b00;
        ResultSrc  = 2'b00;
        PCS        = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        FlagW      = 2'b00;
        NoWrite    = 1'b0;
        InstrDone  = 1'b0;
        State      = FETCH;
        if (reset) begin
            State = state;
            case (state)
                FETCH: begin
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    IRWrite   = MemReady;
                    NextPC    = MemReady;
                end
                DECODE: begin
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    InstrDone = (Op == 2'b11);
                end
                MEMADR: ALUSrcB = 2'b01;
                MEMRD:  AdrSrc  = 1'b1;
                MEMWB: begin
                    ResultSrc = 2'b01;
                    RegW      = 1'b1;
                    PCS       = (Rd == 4'd15);
                    InstrDone = 1'b1;
                end
                MEMWR: begin
                    AdrSrc    = 1'b1;
                    MemW      = 1'b1;
                    InstrDone = MemReady;
                end
                EXECR: begin
                    ALUControl = dec[4:3];
                    FlagW      = dec[1:0];
                end
                EXECI: begin
                    ALUSrcB    = 2'b01;
                    ALUControl = dec[4:3];
                    FlagW      = dec[1:0];
                end
                ALUWB: begin
                    RegW      = 1'b1;
                    NoWrite   = dec[2];
                    PCS       = (Rd == 4'd15) & ~dec[2];
                    InstrDone = 1'b1;
                end
                BRANCH: begin
                    ALUSrcB   = 2'b01;
                    ResultSrc = 2'b10;
                    PCS       = 1'b1;
                    InstrDone = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for main_control_fsm: each step queues the expected output vector,
// and a negedge monitor pops and checks it against the DUT.
module tb_main_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       MemReady;
    logic       IRWrite, NextPC, AdrSrc, ALUSrcA, PCS, RegW, MemW, NoWrite, InstrDone;
    logic [1:0] ALUSrcB, ALUControl, ResultSrc, FlagW;
    logic [3:0] State;

    main_control_fsm #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .MemReady(MemReady),
        .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ResultSrc(ResultSrc), .PCS(PCS),
        .RegW(RegW), .MemW(MemW), .FlagW(FlagW), .NoWrite(NoWrite),
        .InstrDone(InstrDone), .State(State)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [20:0] exp;
    } sb_t;

    sb_t  sb[$];
    sb_t  cur;
    int   tests = 0;
    int   fails = 0;

    logic [20:0] obs;
    assign obs = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc,
                  PCS, RegW, MemW, FlagW, NoWrite, InstrDone, State};

    function automatic logic [20:0] mk(input logic irw, input logic adr, input logic asa,
                                       input logic [1:0] asb, input logic [1:0] alc,
                                       input logic [1:0] rs, input logic pcs, input logic rw,
                                       input logic mw, input logic [1:0] fw, input logic nw,
                                       input logic dn, input logic [3:0] st);
        return {irw, irw, adr, asa, asb, alc, rs, pcs, rw, mw, fw, nw, dn, st};
    endfunction

    function automatic logic [20:0] fetch_e(input logic mr);
        return mk(mr, 0, 1, 2'b10, 2'b00, 2'b10, 0, 0, 0, 2'b00, 0, 0, 4'd0);
    endfunction

    function automatic logic [20:0] decode_e(input logic dn);
        return mk(0, 0, 1, 2'b10, 2'b00, 2'b10, 0, 0, 0, 2'b00, 0, dn, 4'd1);
    endfunction

    task automatic step(input string tag, input logic rst, input logic [1:0] op,
                        input logic [5:0] fn, input logic [3:0] rd, input logic mr,
                        input logic [20:0] e);
        sb_t item;
        reset    = rst;
        Op       = op;
        Funct    = fn;
        Rd       = rd;
        MemReady = mr;
        item.tag = tag;
        item.exp = e;
        sb.push_back(item);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            tests++;
            assert (obs === cur.exp) else begin
                fails++;
                $error("FAIL %s observed=%h expected=%h", cur.tag, obs, cur.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired with %0d checks pending", sb.size());
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b0; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; MemReady = 1'b1;
        @(posedge clk);
        #1;
        // reset held low with memory ready
        step("rst0", 0, 2'b00, 6'b000000, 4'd0, 1, 21'd0);
        step("rst1", 0, 2'b00, 6'b000000, 4'd0, 1, 21'd0);
        step("rst2", 0, 2'b00, 6'b000000, 4'd0, 1, 21'd0);
        // ADDS R1, immediate
        step("adds_f",  1, 2'b00, 6'b101001, 4'd1, 1, fetch_e(1));
        step("adds_d",  1, 2'b00, 6'b101001, 4'd1, 1, decode_e(0));
        step("adds_ei", 1, 2'b00, 6'b101001, 4'd1, 1, mk(0,0,0,2'b01,2'b00,2'b00,0,0,0,2'b11,0,0,4'd7));
        step("adds_wb", 1, 2'b00, 6'b101001, 4'd1, 1, mk(0,0,0,2'b00,2'b00,2'b00,0,1,0,2'b00,0,1,4'd8));
        // CMP register
        step("cmp_f",  1, 2'b00, 6'b010101, 4'd0, 1, fetch_e(1));
        step("cmp_d",  1, 2'b00, 6'b010101, 4'd0, 1, decode_e(0));
        step("cmp_er", 1, 2'b00, 6'b010101, 4'd0, 1, mk(0,0,0,2'b00,2'b01,2'b00,0,0,0,2'b11,0,0,4'd6));
        step("cmp_wb", 1, 2'b00, 6'b010101, 4'd0, 1, mk(0,0,0,2'b00,2'b00,2'b00,0,1,0,2'b00,1,1,4'd8));
        // ORR PC, register, S=0
        step("orr_f",  1, 2'b00, 6'b011000, 4'd15, 1, fetch_e(1));
        step("orr_d",  1, 2'b00, 6'b011000, 4'd15, 1, decode_e(0));
        step("orr_er", 1, 2'b00, 6'b011000, 4'd15, 1, mk(0,0,0,2'b00,2'b11,2'b00,0,0,0,2'b00,0,0,4'd6));
        step("orr_wb", 1, 2'b00, 6'b011000, 4'd15, 1, mk(0,0,0,2'b00,2'b00,2'b00,1,1,0,2'b00,0,1,4'd8));
        // ANDS PC, immediate
        step("ands_f",  1, 2'b00, 6'b100001, 4'd15, 1, fetch_e(1));
        step("ands_d",  1, 2'b00, 6'b100001, 4'd15, 1, decode_e(0));
        step("ands_ei", 1, 2'b00, 6'b100001, 4'd15, 1, mk(0,0,0,2'b01,2'b10,2'b00,0,0,0,2'b10,0,0,4'd7));
        step("ands_wb", 1, 2'b00, 6'b100001, 4'd15, 1, mk(0,0,0,2'b00,2'b00,2'b00,1,1,0,2'b00,0,1,4'd8));
        // SUB R3, register, S=0
        step("sub_f",  1, 2'b00, 6'b000100, 4'd3, 1, fetch_e(1));
        step("sub_d",  1, 2'b00, 6'b000100, 4'd3, 1, decode_e(0));
        step("sub_er", 1, 2'b00, 6'b000100, 4'd3, 1, mk(0,0,0,2'b00,2'b01,2'b00,0,0,0,2'b00,0,0,4'd6));
        step("sub_wb", 1, 2'b00, 6'b000100, 4'd3, 1, mk(0,0,0,2'b00,2'b00,2'b00,0,1,0,2'b00,0,1,4'd8));
        // unsupported cmd 1101 with S=1 targeting PC: no flags, no write
        step("oth_f",  1, 2'b00, 6'b011011, 4'd15, 1, fetch_e(1));
        step("oth_d",  1, 2'b00, 6'b011011, 4'd15, 1, decode_e(0));
        step("oth_er", 1, 2'b00, 6'b011011, 4'd15, 1, mk(0,0,0,2'b00,2'b00,2'b00,0,0,0,2'b00,0,0,4'd6));
        step("oth_wb", 1, 2'b00, 6'b011011, 4'd15, 1, mk(0,0,0,2'b00,2'b00,2'b00,0,1,0,2'b00,1,1,4'd8));
        // LDR PC with two wait cycles
        step("ldr_f",   1, 2'b01, 6'b011001, 4'd15, 1, fetch_e(1));
        step("ldr_d",   1, 2'b01, 6'b011001, 4'd15, 1, decode_e(0));
        step("ldr_ma",  1, 2'b01, 6'b011001, 4'd15, 1, mk(0,0,0,2'b01,2'b00,2'b00,0,0,0,2'b00,0,0,4'd2));
        step("ldr_rd0", 1, 2'b01, 6'b011001, 4'd15, 0, mk(0,1,0,2'b00,2'b00,2'b00,0,0,0,2'b00,0,0,4'd3));
        step("ldr_rd1", 1, 2'b01, 6'b011001, 4'd15, 0, mk(0,1,0,2'b00,2'b00,2'b00,0,0,0,2'b00,0,0,4'd3));
        step("ldr_rd2", 1, 2'b01, 6'b011001, 4'd15, 1, mk(0,1,0,2'b00,2'b00,2'b00,0,0,0,2'b00,0,0,4'd3));
        step("ldr_wb",  1, 2'b01, 6'b011001, 4'd15, 1, mk(0,0,0,2'b00,2'b00,2'b01,1,1,0,2'b00,0,1,4'd4));
        // STR with one wait cycle
        step("str_f",   1, 2'b01, 6'b011000, 4'd2, 1, fetch_e(1));
        step("str_d",   1, 2'b01, 6'b011000, 4'd2, 1, decode_e(0));
        step("str_ma",  1, 2'b01, 6'b011000, 4'd2, 1, mk(0,0,0,2'b01,2'b00,2'b00,0,0,0,2'b00,0,0,4'd2));
        step("str_wr0", 1, 2'b01, 6'b011000, 4'd2, 0, mk(0,1,0,2'b00,2'b00,2'b00,0,0,1,2'b00,0,0,4'd5));
        step("str_wr1", 1, 2'b01, 6'b011000, 4'd2, 1, mk(0,1,0,2'b00,2'b00,2'b00,0,0,1,2'b00,0,1,4'd5));
        // fetch wait, then branch
        step("br_f0",  1, 2'b10, 6'b000000, 4'd0, 0, fetch_e(0));
        step("br_f1",  1, 2'b10, 6'b000000, 4'd0, 1, fetch_e(1));
        step("br_d",   1, 2'b10, 6'b000000, 4'd0, 1, decode_e(0));
        step("br_ex",  1, 2'b10, 6'b000000, 4'd0, 1, mk(0,0,0,2'b01,2'b00,2'b10,1,0,0,2'b00,0,1,4'd9));
        // undefined op retires from DECODE
        step("und_f",  1, 2'b11, 6'b111111, 4'd15, 1, fetch_e(1));
        step("und_d",  1, 2'b11, 6'b111111, 4'd15, 1, decode_e(1));
        step("und_f2", 1, 2'b11, 6'b111111, 4'd15, 1, fetch_e(1));
        step("und_d2", 1, 2'b11, 6'b111111, 4'd15, 1, decode_e(1));
        // reset asserted while a store waits in MEMWR
        step("str2_f",  1, 2'b01, 6'b011000, 4'd4, 1, fetch_e(1));
        step("str2_d",  1, 2'b01, 6'b011000, 4'd4, 1, decode_e(0));
        step("str2_ma", 1, 2'b01, 6'b011000, 4'd4, 1, mk(0,0,0,2'b01,2'b00,2'b00,0,0,0,2'b00,0,0,4'd2));
        step("str2_wr", 1, 2'b01, 6'b011000, 4'd4, 0, mk(0,1,0,2'b00,2'b00,2'b00,0,0,1,2'b00,0,0,4'd5));
        step("rst_wr",  0, 2'b01, 6'b011000, 4'd4, 0, 21'd0);
        step("post_f",  1, 2'b01, 6'b011000, 4'd4, 0, fetch_e(0));
        step("post_f1", 1, 2'b01, 6'b011000, 4'd4, 1, fetch_e(1));
        step("post_d",  1, 2'b01, 6'b011000, 4'd4, 1, decode_e(0));
        step("post_ma", 1, 2'b01, 6'b011000, 4'd4, 1, mk(0,0,0,2'b01,2'b00,2'b00,0,0,0,2'b00,0,0,4'd2));
        @(negedge clk);
        #1;
        tests++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL sb_drain observed=%0d expected=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/main_control_fsm.md
Name: main_control_fsm

Overview:
- Multicycle main controller for the ARM-subset CPU control unit.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Produces the raw write requests that the conditional-execution logic gates with CondEx: PCS, RegW, MemW, FlagW and NoWrite.
- Also drives the datapath mux selects, ALUControl, IRWrite/NextPC, and handshakes with the unified memory through MemReady.

Parameters:
- STATE_W, 4, width of the state register and of the State debug output.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- Op  in  2  Instr[27:26]. 00 data-processing, 01 memory, 10 branch, 11 undefined.
- Funct  in  6  Instr[25:20]. [5]=I, [4:1]=cmd, [0]=S (data-processing) or L (memory).
- Rd  in  4  Instr[15:12].
- MemReady  in  1  memory has completed the current access.
- IRWrite  out  1  load the instruction register.
- NextPC  out  1  unconditional PC load (PC+4).
- AdrSrc  out  1  memory address select. 0=PC, 1=ALUOut.
- ALUSrcA  out  1  0=register A, 1=PC.
- ALUSrcB  out  2  00=register B, 01=ExtImm, 10=constant 4.
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- PCS  out  1  PC write request.
- RegW  out  1  register write request.
- MemW  out  1  memory write request.
- FlagW  out  2  [1]=N,Z update; [0]=C,V update.
- NoWrite  out  1  suppress register write (CMP).
- InstrDone  out  1  one-cycle pulse on the final cycle of each instruction.
- State  out  STATE_W  current state, for debug.

Behaviour:
- State register updates on the rising clk edge. reset==0 at an edge loads FETCH.
- While reset==0, every output is forced to 0. State reads FETCH.
- Reset mid-instruction abandons the instruction; no write request is issued.
- First fetch starts on the first edge after reset goes high.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
- Unused encodings go to FETCH on the next edge with all outputs 0.
- Transitions:
  - FETCH to DECODE only when MemReady=1; otherwise hold.
  - DECODE: Op=01 to MEMADR; Op=00 with I=0 to EXECR; Op=00 with I=1 to EXECI; Op=10 to BRANCH; Op=11 to FETCH (NOP).
  - MEMADR: L=1 to MEMRD, L=0 to MEMWR.
  - MEMRD to MEMWB on MemReady; otherwise hold.
  - MEMWR to FETCH on MemReady; otherwise hold.
  - MEMWB, ALUWB and BRANCH go to FETCH. EXECR and EXECI go to ALUWB.
- Outputs are Moore-style from state, plus Op/Funct/Rd, plus MemReady where noted. Any output not listed for a state is 0.
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10. IRWrite=NextPC=MemReady.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=00.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1, PCS=(Rd==15).
  - MEMWR: AdrSrc=1, MemW=1, held every cycle until MemReady.
  - EXECR: ALUSrcA=0, ALUSrcB=00.
  - EXECI: ALUSrcA=0, ALUSrcB=01.
  - ALUWB: ResultSrc=00, RegW=1, NoWrite per cmd, PCS=(Rd==15)&~NoWrite.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ALUControl=00, ResultSrc=10, PCS=1.
- cmd decode, valid in EXECR, EXECI and ALUWB:
  - 0100 ADD gives ALUControl 00.
  - 0010 SUB gives 01.
  - 0000 AND gives 10.
  - 1100 ORR gives 11.
  - 1010 CMP gives 01 with NoWrite=1.
  - Any other cmd gives 00 with NoWrite=1 and FlagW=00.
- FlagW is nonzero only in EXECR/EXECI:
  - ADD/SUB with S=1 gives 11.
  - AND/ORR with S=1 gives 10.
  - CMP gives 11 regardless of S.
  - S=0 otherwise gives 00.
- InstrDone=1 on the cycle the FSM commits to FETCH: MEMWB, ALUWB, BRANCH, DECODE with Op=11, and MEMWR with MemReady=1.
- Latency with no memory wait states:
  - data-processing 4 cycles
  - branch 3 cycles
  - LDR 5 cycles
  - STR 4 cycles
  - undefined 2 cycles
- Each cycle of MemReady=0 in FETCH, MEMRD or MEMWR adds one cycle.

Test Plan:
- Reset held low 3 cycles with MemReady=1 -> all outputs 0, State=0. After release: IRWrite=NextPC=1 in the first cycle, State=1 next.
- ADDS R1 (Op=00, Funct=101001, Rd=1), MemReady=1 -> State 0,1,7,8. EXECI: ALUControl=00, FlagW=11. ALUWB: RegW=1, PCS=0, InstrDone=1.
- CMP register (Funct=010101, Rd=0) -> EXECR: ALUControl=01, FlagW=11. ALUWB: NoWrite=1, RegW=1, PCS=0.
- LDR PC (Op=01, Funct=011001, Rd=15), MemReady low 2 cycles in MEMRD -> State 0,1,2,3,3,3,4. MEMWB: ResultSrc=01, RegW=1, PCS=1.
- STR (Funct=011000) with MemReady=0 for 1 cycle -> MemW=1 for 2 cycles in MEMWR; InstrDone only on the second.
- Branch (Op=10) -> State 0,1,9, PCS=1 in BRANCH. Op=11 -> DECODE then FETCH, no write request. reset=0 asserted in MEMWR -> MemW=0 and State=0 the next cycle.
